uart_tx_tick: RTL and testbench

Serial transmitter sitting directly downstream of the team's programmable tick timer. Each single-cycle `bitTick` strobe from the timer advances the line by one bit period, so the timer's count sets the baud rate. The block also drives the timer's enable/reset inputs so that bit periods align with the start of each frame. Frame format is 8N1 by default, with optional parity and a second stop bit.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_tick.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_tick.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the tick-driven UART transmitter.
//   uartState_t        : transmitter FSM states
//   PAR_NONE/EVEN/ODD  : parity selection codes
//   DEFAULT_DATA_BITS  : default payload width (8N1)
//   DEFAULT_STOP_BITS  : default number of stop bits
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uartState_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int DEFAULT_DATA_BITS = 8;
  localparam int DEFAULT_STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_tick.sv
// uart_tx_tick: serial transmitter paced by an external bit-period tick timer.
// Each accepted bitTick ends the current bit. The timer is enabled while a
// frame is in flight and cleared once at frame start so bit periods line up
// with the start bit.
//
// Ports:
//   clkSignal  in   clock, rising edge
//   RST        in   synchronous active-high reset
//   EN         in   block enable; low freezes state, forces done/tickRST low
//   data       in   payload, latched when start is accepted
//   start      in   frame request, accepted only in idle
//   bitTick    in   one-cycle bit-period strobe from the timer
//   tx         out  serial line, idle high, registered
//   busy       out  frame in flight
//   done       out  one-cycle pulse at frame end
//   tickEN     out  timer enable (same as busy)
//   tickRST    out  one-cycle timer clear at frame start
//
// state     | meaning
// ST_IDLE   | line high, waiting for start
// ST_START  | sending start bit (0)
// ST_DATA   | sending payload, LSB first
// ST_PARITY | sending parity bit
// ST_STOP   | sending stop bit(s) (1)
module uart_tx_tick
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = DEFAULT_STOP_BITS
) (
  input  logic                 clkSignal,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 start,
  input  logic                 bitTick,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic                 tickEN,
  output logic                 tickRST
);

  localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);
  localparam logic       ODD_INV    = 1'(PARITY == PAR_ODD);
  localparam bit         HAS_PARITY = (PARITY != PAR_NONE);

  uartState_t           state, stateNext;
  logic [DATA_BITS-1:0] shiftReg, shiftNext;
  logic [2:0]           bitCount, bitCountNext;
  logic                 stopCount, stopCountNext;
  logic                 parityBit, parityNext;
  logic                 txNext, busyNext, doneNext, tickRstNext;

  always_ff @(posedge clkSignal) begin
    if (RST) begin
      state     <= ST_IDLE;
      shiftReg  <= '0;
      bitCount  <= '0;
      stopCount <= 1'b0;
      parityBit <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      tickRST   <= 1'b0;
    end else begin
      state     <= stateNext;
      shiftReg  <= shiftNext;
      bitCount  <= bitCountNext;
      stopCount <= stopCountNext;
      parityBit <= parityNext;
      tx        <= txNext;
      busy      <= busyNext;
      done      <= doneNext;
      tickRST   <= tickRstNext;
    end
  end

  // tx is computed for the state being entered so it changes on the same
  // edge as the state register.
  always_comb begin
    stateNext     = state;
    shiftNext     = shiftReg;
    bitCountNext  = bitCount;
    stopCountNext = stopCount;
    parityNext    = parityBit;
    txNext        = tx;
    busyNext      = busy;
    doneNext      = 1'b0;
    tickRstNext   = 1'b0;
    if (EN) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            stateNext     = ST_START;
            shiftNext     = data;
            parityNext    = (^data) ^ ODD_INV;
            bitCountNext  = '0;
            stopCountNext = 1'b0;
            txNext        = 1'b0;
            busyNext      = 1'b1;
            tickRstNext   = 1'b1;
          end
        end
        ST_START: begin
          if (bitTick) begin
            stateNext = ST_DATA;
            txNext    = shiftReg[0];
          end
        end
        ST_DATA: begin
          if (bitTick) begin
            shiftNext = shiftReg >> 1;
            if (bitCount == LAST_BIT) begin
              bitCountNext = '0;
              if (HAS_PARITY) begin
                stateNext = ST_PARITY;
                txNext    = parityBit;
              end else begin
                stateNext = ST_STOP;
                txNext    = 1'b1;
              end
            end else begin
              bitCountNext = bitCount + 3'd1;
              txNext       = shiftReg[1];
            end
          end
        end
        ST_PARITY: begin
          if (bitTick) begin
            stateNext = ST_STOP;
            txNext    = 1'b1;
          end
        end
        ST_STOP: begin
          if (bitTick) begin
            if (stopCount == LAST_STOP) begin
              stateNext     = ST_IDLE;
              stopCountNext = 1'b0;
              busyNext      = 1'b0;
              doneNext      = 1'b1;
            end else begin
              stopCountNext = stopCount + 1'b1;
            end
          end
        end
        default: begin
          stateNext = ST_IDLE;
          txNext    = 1'b1;
          busyNext  = 1'b0;
        end
      endcase
    end
  end

  assign tickEN = busy;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Bench for uart_tx_tick: three configurations share one set of inputs.
//   inst0: 8N1, inst1: 8 bits even parity 2 stop, inst2: 5 bits odd parity 1 stop
// A frame-level model (list of line bits per frame) predicts every output each
// cycle; accepted frames are queued and a monitor rebuilds each frame from the
// line at accepted ticks and compares it when done pulses.
module tb_uart_tx_tick;

  localparam int NI = 3;
  localparam int DB  [NI] = '{8, 8, 5};
  localparam int PAR [NI] = '{0, 1, 2};
  localparam int SB  [NI] = '{1, 2, 1};

  logic       clkSignal = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b1;
  logic [7:0] data = 8'h00;
  logic       start = 1'b0;
  logic       bitTick = 1'b0;

  logic txD [NI];
  logic busyD [NI];
  logic doneD [NI];
  logic tickEnD [NI];
  logic tickRstD [NI];

  int nTests = 0;
  int nFail  = 0;

  always #5 clkSignal = ~clkSignal;

  uart_tx_tick #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clkSignal(clkSignal), .RST(RST), .EN(EN), .data(data), .start(start),
    .bitTick(bitTick), .tx(txD[0]), .busy(busyD[0]), .done(doneD[0]),
    .tickEN(tickEnD[0]), .tickRST(tickRstD[0]));

  uart_tx_tick #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clkSignal(clkSignal), .RST(RST), .EN(EN), .data(data), .start(start),
    .bitTick(bitTick), .tx(txD[1]), .busy(busyD[1]), .done(doneD[1]),
    .tickEN(tickEnD[1]), .tickRST(tickRstD[1]));

  uart_tx_tick #(.DATA_BITS(5), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clkSignal(clkSignal), .RST(RST), .EN(EN), .data(data[4:0]), .start(start),
    .bitTick(bitTick), .tx(txD[2]), .busy(busyD[2]), .done(doneD[2]),
    .tickEN(tickEnD[2]), .tickRST(tickRstD[2]));

  task automatic check(input string name, input int inst, input int act, input int exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s inst%0d t=%0t actual=%0h required=%0h", name, inst, $time, act, exp);
    end
  endtask

  // Line bits of a whole frame, bit k sent k-th: start, data LSB first, parity, stops.
  function automatic logic [15:0] buildFrame(input int i, input logic [7:0] d);
    logic [15:0] f;
    logic p;
    f = '1;
    f[0] = 1'b0;
    p = 1'b0;
    for (int k = 0; k < DB[i]; k++) begin
      f[1+k] = d[k];
      p = p ^ d[k];
    end
    if (PAR[i] != 0) f[1+DB[i]] = (PAR[i] == 2) ? ~p : p;
    return f;
  endfunction

  function automatic int frameLen(input int i);
    return 1 + DB[i] + ((PAR[i] != 0) ? 1 : 0) + SB[i];
  endfunction

  // ---------------- reference model ----------------
  logic        armed = 1'b0;
  logic        mActive [NI];
  logic [15:0] mFrame [NI];
  int          mPos [NI];
  logic        eTx [NI];
  logic        eBusy [NI];
  logic        eDone [NI];
  logic        eTickRst [NI];
  logic [15:0] sbQ [NI][$];

  // Inputs change just after posedge, so at negedge they hold the values the
  // next posedge will sample: check current outputs, then predict that edge.
  always @(negedge clkSignal) begin
    for (int i = 0; i < NI; i++) begin
      if (armed) begin
        check("tx", i, int'(txD[i]), int'(eTx[i]));
        check("busy", i, int'(busyD[i]), int'(eBusy[i]));
        check("done", i, int'(doneD[i]), int'(eDone[i]));
        check("tickEN", i, int'(tickEnD[i]), int'(eBusy[i]));
        check("tickRST", i, int'(tickRstD[i]), int'(eTickRst[i]));
      end
      eDone[i] = 1'b0;
      eTickRst[i] = 1'b0;
      if (RST) begin
        mActive[i] = 1'b0;
        eTx[i] = 1'b1;
        eBusy[i] = 1'b0;
      end else if (EN) begin
        if (!mActive[i]) begin
          if (start) begin
            mFrame[i] = buildFrame(i, data);
            mPos[i] = 0;
            mActive[i] = 1'b1;
            eTx[i] = 1'b0;
            eBusy[i] = 1'b1;
            eTickRst[i] = 1'b1;
            sbQ[i].push_back(mFrame[i]);
          end
        end else if (bitTick) begin
          mPos[i] = mPos[i] + 1;
          if (mPos[i] == frameLen(i)) begin
            mActive[i] = 1'b0;
            eBusy[i] = 1'b0;
            eDone[i] = 1'b1;
            eTx[i] = 1'b1;
          end else begin
            eTx[i] = mFrame[i][mPos[i]];
          end
        end
      end
    end
    if (RST) armed = 1'b1;
  end

  // ---------------- monitor ----------------
  logic [15:0] capBits [NI];
  int          capLen [NI];
  int          framesSeen [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      capBits[i] = '0;
      capLen[i] = 0;
      framesSeen[i] = 0;
    end
  end

  always @(negedge clkSignal) begin
    for (int i = 0; i < NI; i++) begin
      if (armed) begin
        if (doneD[i] === 1'b1) begin
          if (sbQ[i].size() == 0) begin
            check("frame_unexpected", i, 1, 0);
          end else begin
            logic [15:0] exp;
            logic [15:0] mask;
            exp = sbQ[i].pop_front();
            mask = 16'((32'd1 << frameLen(i)) - 1);
            check("frame_len", i, capLen[i], frameLen(i));
            check("frame_bits", i, int'(capBits[i] & mask), int'(exp & mask));
            framesSeen[i]++;
          end
          capBits[i] = '0;
          capLen[i] = 0;
        end
        if (busyD[i] === 1'b1 && EN && bitTick && !RST && capLen[i] < 16) begin
          capBits[i][capLen[i]] = txD[i];
          capLen[i]++;
        end
      end
      if (RST) begin
        sbQ[i].delete();
        capBits[i] = '0;
        capLen[i] = 0;
      end
    end
  end

  // ---------------- tick source ----------------
  int tickMode = 0;
  int tickPer  = 4;
  int tickCnt  = 0;

  always @(posedge clkSignal) begin
    #1;
    tickCnt++;
    if (tickMode == 0) bitTick = ((tickCnt % tickPer) == 0);
    else               bitTick = ($urandom_range(0, 2) == 0);
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clkSignal);
      #1;
    end
  endtask

  task automatic sendOne(input logic [7:0] d);
    data = d;
    start = 1'b1;
    step(1);
    start = 1'b0;
    data = 8'($urandom);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      mActive[i] = 1'b0;
      mPos[i] = 0;
      mFrame[i] = '1;
      eTx[i] = 1'b1;
      eBusy[i] = 1'b0;
      eDone[i] = 1'b0;
      eTickRst[i] = 1'b0;
    end
    step(3);
    RST = 1'b0;
    step(2);

    // 0x55 with ticks every 4 cycles, data scrambled right after acceptance
    sendOne(8'h55);
    step(70);

    // 0x07: even parity 1 on the parity-enabled instance
    sendOne(8'h07);
    step(70);

    // start held high: back-to-back frames, no re-latch mid-frame
    data = 8'hA3;
    start = 1'b1;
    step(110);
    start = 1'b0;
    step(70);

    // EN dropped for 7 cycles in the middle of the data bits, ticks still arriving
    sendOne(8'h96);
    step(14);
    EN = 1'b0;
    step(7);
    EN = 1'b1;
    step(80);

    // reset around the third data bit, then a fresh frame
    sendOne(8'h3C);
    step(13);
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    step(2);
    sendOne(8'hE1);
    step(80);

    // ticks in idle and start while disabled
    tickPer = 2;
    EN = 1'b0;
    start = 1'b1;
    step(10);
    start = 1'b0;
    EN = 1'b1;
    step(10);

    // randomized traffic
    tickMode = 1;
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      data  = 8'($urandom);
      EN    = ($urandom_range(0, 15) != 0);
      RST   = ($urandom_range(0, 499) == 0);
      step(1);
    end

    // drain
    tickMode = 0;
    tickPer = 3;
    start = 1'b0;
    EN = 1'b1;
    RST = 1'b0;
    step(120);

    for (int i = 0; i < NI; i++) begin
      check("scoreboard_empty", i, sbQ[i].size(), 0);
      check("idle_at_end", i, int'(busyD[i]), 0);
      check("frames_seen_min", i, int'(framesSeen[i] >= 8), 1);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
